access_code_correlator: RTL and testbench
=========================================

// Module: access_code_correlator
// PURPOSE
//  Sliding 64-bit sync-word correlator on the received bit stream (rxbit) at the baseband
//  receive front end, directly downstream of the air interface into bt_top.
//  During a search window it scores the last 64 received bits against the programmed sync
//  word (DAC/CAC/GIAC/DIAC selected upstream) and reports the best-scoring bit position
//  above threshold. If no score reaches threshold before the window closes, it reports a timeout.
// PARAMETERS
//  SYNC_W    64  sync word length in bits
//  SCORE_W   7   score width (holds 0..SYNC_W)
//  PEAK_WIN  2   extra bits scanned after first threshold crossing to locate the peak
// PORTS
//  clk_6M               in   1   6 MHz system clock
//  rst                  in   1   synchronous reset, active-high
//  rxbit                in   1   received bit, valid when rxbit_en=1
//  rxbit_en             in   1   1-cycle strobe per received bit (1 Mbps)
//  regi_syncword        in   64  expected sync word; bit 0 is received first
//  regi_correthreshold  in   6   minimum score for a hit (score = matching bits)
//  regi_uncerWinSize    in   9   uncertainty window half-width in bits
//  search_start_p       in   1   start or restart a search
//  search_cancel_p      in   1   abort the search
//  searching            out  1   high in SEARCH or PEAK
//  corr_hit_p           out  1   1-cycle pulse: sync word found
//  corr_score           out  7   best score; valid with corr_hit_p, held until next start
//  hit_offset           out  11  bit count since start at the best bit; held like corr_score
//  corr_timeout_p       out  1   1-cycle pulse: window closed without a hit
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; shift register, fill count and bit count cleared.
//  - Shift: on rxbit_en, shreg <= {rxbit, shreg[63:1]}, in every state. bitcnt (11b, saturating)
//    increments in SEARCH/PEAK. After 64 shifts, shreg[0] holds the oldest bit.
//  - Score: registered one cycle after the shift.
//    score = 64 - popcount(shreg ^ regi_syncword); score_v pulses with it.
//  - A score is eligible only if bitcnt >= 64 at that bit (register fully filled since start).
//  - Window limit L = 64 + 2*regi_uncerWinSize, in bits counted from start.
//  - FSM:
//    IDLE:   on search_start_p -> SEARCH; clear bitcnt, fill, best score/offset.
//    SEARCH: on eligible score_v with score >= regi_correthreshold -> PEAK.
//            Record best = score, offset = bitcnt. Set peakcnt = 0.
//            Else, if bitcnt == L at a score_v -> pulse corr_timeout_p next cycle -> IDLE.
//    PEAK:   on each score_v, peakcnt++. If score > best, update best and offset
//            (ties keep the earlier bit). When peakcnt reaches PEAK_WIN -> pulse corr_hit_p
//            next cycle -> IDLE. With PEAK_WIN = 0, the hit pulses the cycle after the crossing.
//  - Latency: hit pulse is 2 clk after the rxbit_en of the last bit in the peak window.
//  - PEAK is not bounded by L: a crossing on bit L still completes its peak scan.
//  - search_cancel_p: -> IDLE next cycle, no pulse. Cancel wins over a simultaneous start.
//  - search_start_p while in SEARCH/PEAK restarts the search; pending results are discarded.
//  - Threshold 0 is legal: first eligible bit (bitcnt = 64) always crosses.
//  - corr_hit_p and corr_timeout_p are never asserted together.
//  - rst mid-search or mid-peak: same as power-on reset, no pulses.
// TESTING
//  1 Exact match. Start; 10 random bits, then 64'h7e7041e34000000d LSB-first, threshold 60,
//    uncerWin 10. -> corr_hit_p 2 clk after bit 76; score 64; offset 74.
//  2 Four flipped bits in the sync word, threshold 60. -> hit with score 60.
//    Five flipped bits -> no hit; corr_timeout_p after bit 84; searching=0.
//  3 Tie handling. Sync word 64'h0, stream all zeros. -> hit, score 64, offset 64 (earliest of ties).
//  4 Cancel at bit 40 -> searching=0 next cycle; no hit/timeout pulse for 200 further bits.
//    Start+cancel in the same cycle -> stays IDLE.
//  5 Restart in PEAK (start at first crossing+1) -> old result dropped; bitcnt restarts;
//    new hit offset counted from the new start.
//  6 rst asserted during PEAK -> all outputs 0 next cycle; IDLE; no pulses until a new start.

Source files
------------

// File: rtl/access_code_correlator_if.sv
// Receive-side bus of the access code correlator: bit stream, search configuration
// and control, plus the search status and result outputs.
interface access_code_correlator_if #(
  parameter int unsigned SYNC_W  = 64,
  parameter int unsigned SCORE_W = 7
);
  logic               rxbit;
  logic               rxbit_en;
  logic [SYNC_W-1:0]  regi_syncword;
  logic [5:0]         regi_correthreshold;
  logic [8:0]         regi_uncerWinSize;
  logic               search_start_p;
  logic               search_cancel_p;
  logic               searching;
  logic               corr_hit_p;
  logic [SCORE_W-1:0] corr_score;
  logic [10:0]        hit_offset;
  logic               corr_timeout_p;

  modport master (
    output rxbit, rxbit_en, regi_syncword, regi_correthreshold, regi_uncerWinSize,
           search_start_p, search_cancel_p,
    input  searching, corr_hit_p, corr_score, hit_offset, corr_timeout_p
  );

  modport slave (
    input  rxbit, rxbit_en, regi_syncword, regi_correthreshold, regi_uncerWinSize,
           search_start_p, search_cancel_p,
    output searching, corr_hit_p, corr_score, hit_offset, corr_timeout_p
  );
endinterface

// File: rtl/access_code_correlator.sv
// Sliding sync-word correlator: scores the last SYNC_W received bits against the programmed
// sync word during a search window and reports the best peak position or a timeout.
module access_code_correlator #(
  parameter int unsigned SYNC_W   = 64,
  parameter int unsigned SCORE_W  = 7,
  parameter int unsigned PEAK_WIN = 2
) (
  input  logic                    clk_6M,
  input  logic                    rst,
  access_code_correlator_if.slave bus
);
  localparam int unsigned CNT_W = 11;
  localparam int unsigned PK_W  = 8;

  typedef enum logic [1:0] {IDLE, SEARCH, PEAK} state_e;

  state_e             state_q;
  logic [SYNC_W-1:0]  shreg_q;
  logic [CNT_W-1:0]   bitcnt_q;
  logic [CNT_W-1:0]   best_off_q;
  logic [CNT_W-1:0]   hit_offset_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] best_q;
  logic [SCORE_W-1:0] corr_score_q;
  logic [PK_W-1:0]    peakcnt_q;
  logic               en_d_q;
  logic               score_v_q;
  logic               searching_q;
  logic               hit_q;
  logic               timeout_q;

  logic [SCORE_W-1:0] score_d;
  logic [CNT_W-1:0]   limit_c;
  logic [PK_W-1:0]    peak_next_c;
  logic               cross_c;
  logic               better_c;
  logic               peak_done_c;

  // Number of register bits matching the sync word.
  always_comb begin
    score_d = SCORE_W'(SYNC_W);
    for (int i = 0; i < SYNC_W; i++) begin
      if (shreg_q[i] != bus.regi_syncword[i]) score_d = score_d - SCORE_W'(1);
    end
  end

  assign limit_c     = CNT_W'(SYNC_W) + CNT_W'({bus.regi_uncerWinSize, 1'b0});
  assign cross_c     = score_v_q && (bitcnt_q >= CNT_W'(SYNC_W)) &&
                       (score_q >= SCORE_W'(bus.regi_correthreshold));
  assign better_c    = score_q > best_q;
  assign peak_next_c = peakcnt_q + PK_W'(1);
  assign peak_done_c = peak_next_c == PK_W'(PEAK_WIN);

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      best_off_q   <= '0;
      hit_offset_q <= '0;
      score_q      <= '0;
      best_q       <= '0;
      corr_score_q <= '0;
      peakcnt_q    <= '0;
      en_d_q       <= 1'b0;
      score_v_q    <= 1'b0;
      searching_q  <= 1'b0;
      hit_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
      en_d_q    <= bus.rxbit_en;
      score_v_q <= en_d_q;
      score_q   <= score_d;
      if (bus.rxbit_en) shreg_q <= {bus.rxbit, shreg_q[SYNC_W-1:1]};
      if (bus.rxbit_en && (state_q != IDLE) && (bitcnt_q != '1)) bitcnt_q <= bitcnt_q + CNT_W'(1);

      // Cancel beats start; start from any state restarts with cleared results.
      if (bus.search_cancel_p) begin
        state_q     <= IDLE;
        searching_q <= 1'b0;
      end else if (bus.search_start_p) begin
        state_q      <= SEARCH;
        searching_q  <= 1'b1;
        bitcnt_q     <= '0;
        best_q       <= '0;
        best_off_q   <= '0;
        peakcnt_q    <= '0;
        corr_score_q <= '0;
        hit_offset_q <= '0;
      end else begin
        case (state_q)
          SEARCH: begin
            if (cross_c) begin
              best_q     <= score_q;
              best_off_q <= bitcnt_q;
              peakcnt_q  <= '0;
              if (PEAK_WIN == 0) begin
                hit_q        <= 1'b1;
                corr_score_q <= score_q;
                hit_offset_q <= bitcnt_q;
                state_q      <= IDLE;
                searching_q  <= 1'b0;
              end else begin
                state_q <= PEAK;
              end
            end else if (score_v_q && (bitcnt_q == limit_c)) begin
              timeout_q   <= 1'b1;
              state_q     <= IDLE;
              searching_q <= 1'b0;
            end
          end
          PEAK: begin
            if (score_v_q) begin
              peakcnt_q <= peak_next_c;
              // Strictly greater keeps the earliest of equal scores.
              if (better_c) begin
                best_q     <= score_q;
                best_off_q <= bitcnt_q;
              end
              if (peak_done_c) begin
                hit_q        <= 1'b1;
                corr_score_q <= better_c ? score_q : best_q;
                hit_offset_q <= better_c ? bitcnt_q : best_off_q;
                state_q      <= IDLE;
                searching_q  <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.searching      = searching_q;
  assign bus.corr_hit_p     = hit_q;
  assign bus.corr_score     = corr_score_q;
  assign bus.hit_offset     = hit_offset_q;
  assign bus.corr_timeout_p = timeout_q;
endmodule

// File: tb/tb_access_code_correlator.sv
// Randomized scoreboard bench for access_code_correlator: a bit-list reference model queues
// expected hit/timeout pulses and a negedge monitor matches them against the DUT.
module tb_access_code_correlator;
  localparam int SYNC_W   = 64;
  localparam int PEAK_WIN = 2;

  typedef struct {
    bit is_hit;
    int cyc;
    int score;
    int off;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  access_code_correlator_if bus ();

  access_code_correlator #(.SYNC_W(64), .SCORE_W(7), .PEAK_WIN(PEAK_WIN)) dut (
    .clk_6M(clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: bits received since the last start.
  bit [63:0] m_sync;
  int        m_thr;
  int        m_limit;
  bit        m_bits[$];
  bit        m_active = 1'b0;
  bit        m_peak = 1'b0;
  int        m_best, m_off, m_pk;
  int        m_last_score = 0;
  int        m_last_off = 0;
  exp_t      exp_q[$];

  function automatic void chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  function automatic void push_hit(input int edge_id);
    exp_t e;
    e.is_hit = 1'b1;
    e.cyc    = edge_id + 2;
    e.score  = m_best;
    e.off    = m_off;
    exp_q.push_back(e);
    m_last_score = m_best;
    m_last_off   = m_off;
    m_active     = 1'b0;
    m_peak       = 1'b0;
  endfunction

  function automatic void model_bit(input bit b, input int edge_id);
    int   n;
    int   sc;
    exp_t e;
    if (!m_active) return;
    m_bits.push_back(b);
    n  = m_bits.size();
    sc = 0;
    if (n >= SYNC_W)
      for (int i = 0; i < SYNC_W; i++) if (m_bits[n-SYNC_W+i] == m_sync[i]) sc++;
    if (!m_peak) begin
      if (n >= SYNC_W && sc >= m_thr) begin
        m_best = sc;
        m_off  = n;
        m_pk   = 0;
        if (PEAK_WIN == 0) push_hit(edge_id);
        else m_peak = 1'b1;
      end else if (n == m_limit) begin
        e.is_hit = 1'b0;
        e.cyc    = edge_id + 2;
        e.score  = 0;
        e.off    = 0;
        exp_q.push_back(e);
        m_active = 1'b0;
      end
    end else begin
      m_pk++;
      if (sc > m_best) begin
        m_best = sc;
        m_off  = n;
      end
      if (m_pk == PEAK_WIN) push_hit(edge_id);
    end
  endfunction

  // Scoreboard monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.corr_hit_p === 1'b1 || bus.corr_timeout_p === 1'b1) begin
      chk("pulse_exclusive", int'(bus.corr_hit_p & bus.corr_timeout_p), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: hit=%0b timeout=%0b with nothing expected (cycle %0d)",
                 bus.corr_hit_p, bus.corr_timeout_p, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_hit", int'(bus.corr_hit_p), int'(e.is_hit));
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_score", int'(bus.corr_score), e.score);
        chk("pulse_offset", int'(bus.hit_offset), e.off);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse: no pulse seen, expected %s at cycle %0d (now %0d)",
               e.is_hit ? "hit" : "timeout", e.cyc, cyc);
    end
  end

  task automatic set_cfg(input bit [63:0] sync, input int thr, input int win);
    bus.regi_syncword       = sync;
    bus.regi_correthreshold = 6'(thr);
    bus.regi_uncerWinSize   = 9'(win);
    m_sync  = sync;
    m_thr   = thr;
    m_limit = SYNC_W + 2 * win;
  endtask

  task automatic start_search();
    @(negedge clk);
    bus.search_start_p = 1'b1;
    m_bits.delete();
    m_active     = 1'b1;
    m_peak       = 1'b0;
    m_last_score = 0;
    m_last_off   = 0;
    @(negedge clk);
    bus.search_start_p = 1'b0;
  endtask

  task automatic cancel_search(input bit with_start);
    @(negedge clk);
    bus.search_cancel_p = 1'b1;
    bus.search_start_p  = with_start;
    m_active = 1'b0;
    m_peak   = 1'b0;
    @(negedge clk);
    bus.search_cancel_p = 1'b0;
    bus.search_start_p  = 1'b0;
    chk("cancel_searching", int'(bus.searching), 0);
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    bus.rxbit    = b;
    bus.rxbit_en = 1'b1;
    model_bit(b, cyc + 1);
    @(negedge clk);
    bus.rxbit_en = 1'b0;
    bus.rxbit    = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input bit [63:0] w);
    for (int i = 0; i < 64; i++) send_bit(w[i]);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  // Feeds random bits until the model closes the search, then checks the held results.
  task automatic run_until_idle(input string name, input int max_bits);
    int k = 0;
    while (m_active && k < max_bits) begin
      send_bit(1'($urandom));
      k++;
    end
    if (m_active) begin
      checks++;
      errors++;
      $display("FAIL %s_bound: search still open after %0d bits", name, max_bits);
      m_active = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk({name, "_searching"}, int'(bus.searching), 0);
    chk({name, "_held_score"}, int'(bus.corr_score), m_last_score);
    chk({name, "_held_offset"}, int'(bus.hit_offset), m_last_off);
  endtask

  function automatic bit [63:0] flip_mask(input int k);
    bit [63:0] m;
    m = '0;
    while ($countones(m) < k) m[$urandom_range(0, 63)] = 1'b1;
    return m;
  endfunction

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [63:0] sw;
    bus.rxbit = 1'b0;
    bus.rxbit_en = 1'b0;
    bus.search_start_p = 1'b0;
    bus.search_cancel_p = 1'b0;
    sw = 64'h7e7041e34000000d;
    set_cfg(sw, 60, 10);
    repeat (3) @(negedge clk);
    chk("rst_searching", int'(bus.searching), 0);
    chk("rst_hit", int'(bus.corr_hit_p), 0);
    chk("rst_timeout", int'(bus.corr_timeout_p), 0);
    chk("rst_score", int'(bus.corr_score), 0);
    chk("rst_offset", int'(bus.hit_offset), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Exact match after a 10-bit random prefix.
    start_search();
    chk("start_searching", int'(bus.searching), 1);
    send_random(10);
    send_word(sw);
    run_until_idle("t1", 40);
    chk("t1_score", int'(bus.corr_score), 64);
    chk("t1_offset", int'(bus.hit_offset), 74);

    // Four flipped bits still hit at threshold 60; five time out.
    start_search();
    send_random(10);
    send_word(sw ^ flip_mask(4));
    run_until_idle("t2a", 40);
    chk("t2a_score", int'(bus.corr_score), 60);
    start_search();
    send_random(10);
    send_word(sw ^ flip_mask(5));
    run_until_idle("t2b", 40);

    // All-zero word and stream: every window ties, earliest wins.
    set_cfg(64'h0, 60, 10);
    start_search();
    for (int i = 0; i < 66; i++) send_bit(1'b0);
    run_until_idle("t3", 10);
    chk("t3_offset", int'(bus.hit_offset), 64);

    // Cancel mid-search, then a long quiet stretch; start+cancel together stays idle.
    set_cfg(sw, 60, 10);
    start_search();
    send_random(40);
    chk("t4_searching_before", int'(bus.searching), 1);
    cancel_search(1'b0);
    send_random(200);
    cancel_search(1'b1);
    send_random(20);
    chk("t4_idle_after", int'(bus.searching), 0);

    // Restart while scanning the peak: the new offset counts from the new start.
    start_search();
    send_random(10);
    send_word(sw);
    send_random(1);
    chk("t5_in_peak", int'(m_peak), 1);
    start_search();
    send_random(20);
    send_word(sw);
    run_until_idle("t5", 40);
    chk("t5_offset", int'(bus.hit_offset), 84);

    // Reset during the peak scan clears everything and stays silent.
    start_search();
    send_random(5);
    send_word(sw);
    @(negedge clk);
    rst = 1'b1;
    m_active = 1'b0;
    m_peak = 1'b0;
    @(negedge clk);
    chk("t6_searching", int'(bus.searching), 0);
    chk("t6_hit", int'(bus.corr_hit_p), 0);
    chk("t6_score", int'(bus.corr_score), 0);
    chk("t6_offset", int'(bus.hit_offset), 0);
    rst = 1'b0;
    send_random(80);

    // Threshold zero: the first eligible bit always crosses.
    set_cfg(64'($urandom) | (64'($urandom) << 32), 0, 5);
    start_search();
    run_until_idle("thr0", 100);
    chk("thr0_offset_min", int'(bus.hit_offset >= 11'd64 && bus.hit_offset <= 11'd66), 1);

    // Randomized configurations and impaired sync words.
    for (int t = 0; t < 8; t++) begin
      sw = 64'($urandom) | (64'($urandom) << 32);
      set_cfg(sw, $urandom_range(40, 63), $urandom_range(0, 30));
      start_search();
      send_random($urandom_range(0, 20));
      send_word(sw ^ flip_mask($urandom_range(0, 6)));
      run_until_idle("rand", 150);
    end

    repeat (10) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
